mem_rr_arbiter: RTL and testbench
=================================

# mem_rr_arbiter

Round-robin arbiter that shares one slave port among the `picorv32` cores' native memory interfaces. The port can be the SRAM port or a single interconnect slave. It accepts `mem_valid`/`mem_ready` requests from N masters, registers the winner's request, and drives a req/gnt/rvalid slave handshake. It returns read data and a one-cycle ready pulse to the winner only. It also bounds every transaction with a timeout so a hung slave cannot stall the cores.

## Interface
- `N_MASTERS`, 4: number of requesters; must be ≥2. `IDX_W = $clog2(N_MASTERS)`.
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width; byte strobes are `DATA_WIDTH/8` bits wide.
- `TIMEOUT_CYCLES`, 255: maximum cycles from slave request to response; 8-bit counter; must be ≥2.

Ports:
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `m_valid` in N: per-master request.
- `m_addr` in N*ADDR_WIDTH: packed addresses; master i occupies `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `m_wdata` in N*DATA_WIDTH: packed write data.
- `m_wstrb` in N*DATA_WIDTH/8: packed byte strobes; all-zero means read.
- `m_rdata` out N*DATA_WIDTH: per-master registered read data.
- `m_ready` out N: per-master completion pulse.
- `s_req` out 1: slave request.
- `s_we` out 1: slave write enable.
- `s_addr` out ADDR_WIDTH: slave address.
- `s_wdata` out DATA_WIDTH: slave write data.
- `s_be` out DATA_WIDTH/8: slave byte enables.
- `s_gnt` in 1: slave accepted the request.
- `s_rvalid` in 1: slave response; required for both reads and writes.
- `s_rdata` in DATA_WIDTH: slave read data.
- `grant` out N: one-hot current owner; all-zero when idle.
- `timeout` out 1: one-cycle pulse when a transaction is aborted by timeout.

## Operation
- States: IDLE, REQ, RESP, DONE. Registers: `state`, `owner` (IDX_W), `rr_ptr` (IDX_W), latched `addr`/`wdata`/`wstrb`, `tcnt` (8 bit).
- **IDLE**
  - If any `m_valid`, select the first index with `m_valid` set, scanning from `rr_ptr` upward modulo N.
  - Latch that master's addr, wdata and wstrb. Set `owner` and `grant`, clear `tcnt`, go to REQ.
- **REQ**
  - Drive `s_req`=1, `s_addr`/`s_wdata`/`s_be` from the latched values, and `s_we` = OR of the latched wstrb.
  - On `s_gnt`, go to RESP.
  - `s_rvalid` in REQ is ignored; a response counts only from the cycle after `s_gnt` is sampled.
- **RESP**
  - `s_req`=0.
  - On `s_rvalid`: latch `s_rdata` into `m_rdata[owner]`, set `m_ready[owner]`, go to DONE.
- **DONE**
  - `m_ready[owner]`=1 for exactly this cycle.
  - Set `rr_ptr` = (owner+1) mod N; clear `grant`; go to IDLE.
- **Timeout**
  - `tcnt` increments every cycle in REQ or RESP.
  - If `tcnt` reaches TIMEOUT_CYCLES before completion:
    - load all-ones into `m_rdata[owner]`;
    - pulse `timeout` and `m_ready[owner]`;
    - go to DONE. A write is considered dropped.
  - A completion in the same cycle as `tcnt` = TIMEOUT_CYCLES wins; there is no timeout pulse.
- A master dropping `m_valid` mid-transaction does not abort it; the transaction completes and `m_ready` still pulses.
- `m_rdata` for non-owners holds its last value. Masters must not change request fields while valid and unserved; this is `picorv32` behaviour.
- Fairness: with all N masters requesting continuously, each is served exactly once per N transactions.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from `m_*` to `s_*`.
- Reset (async assert, sync release):
  - state IDLE; `rr_ptr`=0, `owner`=0, `tcnt`=0;
  - `s_req`=0, `s_we`=0, `s_addr`/`s_wdata`/`s_be`=0;
  - `m_ready`=0, `m_rdata`=0, `grant`=0, `timeout`=0.
- Reset mid-transaction abandons the transaction immediately; no `m_ready` is issued.
- Minimum latency, with `m_valid` seen in IDLE at cycle T:
  - `s_req` at T+1;
  - if `s_gnt` at T+1, RESP at T+2;
  - if `s_rvalid` at T+2, `m_ready` at T+3;
  - IDLE at T+4.
  - Total throughput: one transaction per 4 cycles minimum.
- The DONE cycle guarantees `picorv32` has deasserted `m_valid` before the next arbitration. A served master is therefore never re-selected on stale valid.
- `s_gnt` withheld for k cycles extends REQ by k. `s_rvalid` delay extends RESP.

## Test plan
- Single master: master 2 reads 0x10 with `s_gnt`=1, `s_rvalid` one cycle later, `s_rdata`=0xCAFEF00D -> `s_req` at T+1, `m_ready[2]` at T+3 with `m_rdata[2]`=0xCAFEF00D, `rr_ptr`=3.
- Write: master 0 writes 0x12345678 with wstrb 0x3 to 0x20 -> `s_we`=1, `s_be`=0x3, `s_addr`=0x20; `m_ready[0]` after `s_rvalid`.
- Contention: all 4 masters request continuously from reset -> grant order 0,1,2,3,0 with one `m_ready` per transaction and no master served twice within 4 transactions.
- Timeout: `s_gnt`=1 and `s_rvalid` never asserted, TIMEOUT_CYCLES=8 -> `timeout` and `m_ready[owner]` pulse together, `m_rdata`=0xFFFFFFFF; the next requester is served normally.
- Reset in RESP: assert `resetn`=0 while waiting for `s_rvalid` -> all outputs zero asynchronously and no `m_ready`; after release, the pending master is re-served starting from `rr_ptr`=0.
- Backpressure: `s_gnt` held low for 5 cycles -> `s_req` and fields stable for 6 cycles; completes normally.

Source files
------------

// File: rtl/mem_rr_arbiter_if.sv
// Slave-side bus of the round-robin memory arbiter: a req/gnt request phase
// followed by an rvalid response phase (responses are required for writes too).
interface mem_rr_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    s_req;
  logic                    s_we;
  logic [ADDR_WIDTH-1:0]   s_addr;
  logic [DATA_WIDTH-1:0]   s_wdata;
  logic [DATA_WIDTH/8-1:0] s_be;
  logic                    s_gnt;
  logic                    s_rvalid;
  logic [DATA_WIDTH-1:0]   s_rdata;

  // The arbiter masters the bus; the memory or interconnect is the slave.
  modport master (
    output s_req, s_we, s_addr, s_wdata, s_be,
    input  s_gnt, s_rvalid, s_rdata
  );

  modport slave (
    input  s_req, s_we, s_addr, s_wdata, s_be,
    output s_gnt, s_rvalid, s_rdata
  );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one slave port among several picorv32 native
// memory interfaces, with a per-transaction timeout so a hung slave cannot
// stall the cores.
//
// state | meaning
// IDLE  | no owner; pick the first m_valid at or after rr_ptr
// REQ   | s_req high with the latched fields until s_gnt
// RESP  | request accepted, waiting for s_rvalid
// DONE  | m_ready pulse to the owner; rr_ptr moves past it
module mem_rr_arbiter #(
  parameter int N_MASTERS      = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [N_MASTERS-1:0]              m_valid,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0]   m_addr,
  input  logic [N_MASTERS*DATA_WIDTH-1:0]   m_wdata,
  input  logic [N_MASTERS*DATA_WIDTH/8-1:0] m_wstrb,
  output logic [N_MASTERS*DATA_WIDTH-1:0]   m_rdata,
  output logic [N_MASTERS-1:0]              m_ready,
  mem_rr_arbiter_if.master                  s_bus,
  output logic [N_MASTERS-1:0]              grant,
  output logic                              timeout
);
  localparam int         IDX_W    = $clog2(N_MASTERS);
  localparam int         STRB_W   = DATA_WIDTH / 8;
  localparam logic [7:0] TCNT_MAX = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t              state;
  logic [IDX_W-1:0]    owner;
  logic [IDX_W-1:0]    rr_ptr;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                we_q;
  logic                req_q;
  logic [7:0]          tcnt;

  logic                sel_found;
  logic [IDX_W-1:0]    sel_idx;
  logic [IDX_W-1:0]    cand;

  function automatic logic [N_MASTERS-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Wrap explicitly so non-power-of-two master counts stay in range.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    if (int'(idx) == N_MASTERS - 1) next_idx = '0;
    else                            next_idx = idx + 1'b1;
  endfunction

  // Pick the first requesting master at or after rr_ptr, wrapping modulo N.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % N_MASTERS);
      if (!sel_found && m_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Transaction FSM; every output is a flop written here, so nothing on the
  // m_* side reaches the s_* side combinationally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      owner   <= '0;
      rr_ptr  <= '0;
      tcnt    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      we_q    <= 1'b0;
      req_q   <= 1'b0;
      m_ready <= '0;
      m_rdata <= '0;
      grant   <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_found) begin
            owner   <= sel_idx;
            grant   <= onehot(sel_idx);
            addr_q  <= m_addr[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_q <= m_wdata[sel_idx*DATA_WIDTH +: DATA_WIDTH];
            wstrb_q <= m_wstrb[sel_idx*STRB_W +: STRB_W];
            we_q    <= |m_wstrb[sel_idx*STRB_W +: STRB_W];
            tcnt    <= '0;
            req_q   <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          // A response seen here cannot belong to this request and is ignored.
          if (tcnt == TCNT_MAX) begin
            req_q                                  <= 1'b0;
            m_rdata[owner*DATA_WIDTH +: DATA_WIDTH] <= '1;
            m_ready                                <= onehot(owner);
            timeout                                <= 1'b1;
            state                                  <= DONE;
          end else begin
            tcnt <= tcnt + 8'd1;
            if (s_bus.s_gnt) begin
              req_q <= 1'b0;
              state <= RESP;
            end
          end
        end
        RESP: begin
          // A response on the final counted cycle still completes normally.
          if (s_bus.s_rvalid) begin
            m_rdata[owner*DATA_WIDTH +: DATA_WIDTH] <= s_bus.s_rdata;
            m_ready                                <= onehot(owner);
            state                                  <= DONE;
          end else if (tcnt == TCNT_MAX) begin
            m_rdata[owner*DATA_WIDTH +: DATA_WIDTH] <= '1;
            m_ready                                <= onehot(owner);
            timeout                                <= 1'b1;
            state                                  <= DONE;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        DONE: begin
          // One idle cycle follows so the served master has dropped m_valid
          // before the next arbitration.
          m_ready <= '0;
          grant   <= '0;
          rr_ptr  <= next_idx(owner);
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s_bus.s_req   = req_q;
  assign s_bus.s_we    = we_q;
  assign s_bus.s_addr  = addr_q;
  assign s_bus.s_wdata = wdata_q;
  assign s_bus.s_be    = wstrb_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: a transaction-level slave/master model drives the
// arbiter and predicts winners, bus fields, response timing and read data.
module tb_mem_rr_arbiter;
  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 8;

  logic            clk = 1'b0;
  logic            resetn;
  logic [N-1:0]    m_valid;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N*SW-1:0] m_wstrb;
  logic [N*DW-1:0] m_rdata;
  logic [N-1:0]    m_ready;
  logic [N-1:0]    grant;
  logic            timeout;

  mem_rr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_rr_arbiter #(
    .N_MASTERS     (N),
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .m_valid(m_valid),
    .m_addr (m_addr),
    .m_wdata(m_wdata),
    .m_wstrb(m_wstrb),
    .m_rdata(m_rdata),
    .m_ready(m_ready),
    .s_bus  (bus),
    .grant  (grant),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  int              n_chk  = 0;
  int              n_pass = 0;
  int              exp_ptr;
  logic [N*DW-1:0] exp_mrdata;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Round-robin rule: first pending master at or after the pointer, modulo N.
  function automatic int rr_pick();
    int j;
    for (int k = 0; k < N; k++) begin
      j = (exp_ptr + k) % N;
      if (m_valid[j]) return j;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    m_addr[i*AW +: AW]  = a;
    m_wdata[i*DW +: DW] = d;
    m_wstrb[i*SW +: SW] = s;
    m_valid[i]          = 1'b1;
  endtask

  task automatic rand_req(input int i);
    logic [3:0] s;
    s = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
    set_req(i, $urandom & 32'hFFFF_FFFC, $urandom, s);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"},  grant,        '0);
    chk({tag, "_ready"},  m_ready,      '0);
    chk({tag, "_rdata"},  m_rdata,      '0);
    chk({tag, "_timeout"}, timeout,     '0);
    chk({tag, "_sreq"},   bus.s_req,    '0);
    chk({tag, "_swe"},    bus.s_we,     '0);
    chk({tag, "_saddr"},  bus.s_addr,   '0);
    chk({tag, "_swdata"}, bus.s_wdata,  '0);
    chk({tag, "_sbe"},    bus.s_be,     '0);
  endtask

  // Called at the negedge of a cycle in which the arbiter is idle, with the
  // request set already driven. gd: cycles s_gnt is withheld; rd: cycles
  // before s_rvalid once granted, or -1 for a slave that never answers.
  task automatic run_txn(input int gd, input int rd, input bit noisy, input bit drop,
                         input logic [31:0] rdv);
    int          win;
    int          c;
    logic [31:0] ea, ew, exp_rd;
    logic [3:0]  es;
    logic        exp_to;
    win = rr_pick();
    if (win < 0) return;
    ea = m_addr[win*AW +: AW];
    ew = m_wdata[win*DW +: DW];
    es = m_wstrb[win*SW +: SW];
    @(negedge clk);
    chk("grant",    grant,       oh(win));
    chk("sreq_on",  bus.s_req,   1'b1);
    chk("saddr",    bus.s_addr,  ea);
    chk("swdata",   bus.s_wdata, ew);
    chk("sbe",      bus.s_be,    es);
    chk("swe",      bus.s_we,    |es);
    chk("no_ready", m_ready,     '0);
    if (drop) begin
      m_valid[win]        = 1'b0;
      m_addr[win*AW +: AW] = $urandom;
      m_wstrb[win*SW +: SW] = 4'($urandom);
    end
    for (int k = 0; k < gd; k++) begin
      bus.s_gnt    = 1'b0;
      bus.s_rvalid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.s_rdata  = $urandom;
      @(negedge clk);
      chk("req_hold",   bus.s_req,   1'b1);
      chk("addr_hold",  bus.s_addr,  ea);
      chk("wdata_hold", bus.s_wdata, ew);
      chk("be_hold",    bus.s_be,    es);
    end
    bus.s_gnt    = 1'b1;
    bus.s_rvalid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge clk);
    bus.s_gnt = 1'b0;
    chk("sreq_off", bus.s_req, 1'b0);
    if (rd >= 0) begin
      for (int k = 0; k < rd; k++) begin
        bus.s_rvalid = 1'b0;
        @(negedge clk);
        chk("early_ready", m_ready, '0);
      end
      bus.s_rvalid = 1'b1;
      bus.s_rdata  = rdv;
      @(negedge clk);
      bus.s_rvalid = 1'b0;
      exp_rd = rdv;
      exp_to = 1'b0;
    end else begin
      // With s_gnt taken on the first REQ cycle, the counter sees TMO+1 busy
      // cycles, so DONE shows up TMO negedges after the first RESP sample.
      c = 0;
      bus.s_rvalid = 1'b0;
      while (m_ready == '0 && c < 60) begin
        @(negedge clk);
        c++;
      end
      chk("to_latency", c, TMO);
      exp_rd = 32'hFFFF_FFFF;
      exp_to = 1'b1;
    end
    chk("ready",   m_ready, oh(win));
    chk("timeout", timeout, exp_to);
    exp_mrdata[win*DW +: DW] = exp_rd;
    chk("rdata",   m_rdata, exp_mrdata);
    m_valid[win] = 1'b0;
    exp_ptr      = (win + 1) % N;
    @(negedge clk);
    chk("idle_ready",   m_ready, '0);
    chk("idle_grant",   grant,   '0);
    chk("idle_timeout", timeout, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    resetn       = 1'b1;
    m_valid      = '0;
    m_addr       = '0;
    m_wdata      = '0;
    m_wstrb      = '0;
    bus.s_gnt    = 1'b0;
    bus.s_rvalid = 1'b0;
    bus.s_rdata  = '0;
    exp_ptr      = 0;
    exp_mrdata   = '0;
    #3 resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");

    // All masters requesting from reset: served 0,1,2,3,0, each re-requesting
    // in the idle cycle after its ready.
    for (int i = 0; i < N; i++) rand_req(i);
    resetn = 1'b1;
    for (int t = 0; t < 5; t++) begin
      run_txn($urandom_range(0, 2), $urandom_range(0, 2), 1'b0, 1'b0, $urandom);
      rand_req((exp_ptr + N - 1) % N);
    end
    m_valid = '0;

    // Single master read.
    set_req(2, 32'h10, $urandom, 4'h0);
    run_txn(0, 0, 1'b0, 1'b0, 32'hCAFE_F00D);
    chk("rr_ptr_after_m2", dut.rr_ptr, 2'd3);

    // Write with partial strobes.
    set_req(0, 32'h20, 32'h1234_5678, 4'h3);
    run_txn(1, 1, 1'b0, 1'b0, $urandom);

    // Backpressure: s_gnt withheld 5 cycles, stray rvalid during REQ.
    set_req(1, 32'h44, 32'hA5A5_0F0F, 4'hF);
    run_txn(5, 2, 1'b1, 1'b0, $urandom);

    // Timeout on master 3, then master 0 served normally.
    set_req(3, 32'h80, $urandom, 4'h0);
    set_req(0, 32'h84, $urandom, 4'h0);
    run_txn(0, -1, 1'b0, 1'b0, $urandom);
    run_txn(0, 1, 1'b0, 1'b0, $urandom);

    // Response on the last counted cycle beats the timeout.
    set_req(1, 32'h90, $urandom, 4'h0);
    run_txn(0, TMO - 1, 1'b0, 1'b0, 32'h0BAD_BEEF);

    // Reset while waiting for s_rvalid.
    set_req(2, 32'hA0, $urandom, 4'h0);
    run_txn(0, 0, 1'b0, 1'b0, $urandom);
    set_req(1, 32'hB0, $urandom, 4'h0);
    set_req(3, 32'hC0, $urandom, 4'h0);
    @(negedge clk);
    chk("pre_reset_grant", grant, oh(3));
    bus.s_gnt = 1'b1;
    @(negedge clk);
    bus.s_gnt = 1'b0;
    #1 resetn = 1'b0;
    #1 chk_all_zero("async_reset");
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("reset_no_ready", m_ready, '0);
    end
    exp_ptr    = 0;
    exp_mrdata = '0;
    resetn     = 1'b1;
    run_txn(0, 0, 1'b0, 1'b0, $urandom);
    run_txn(1, 0, 1'b0, 1'b0, $urandom);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++)
        if (!m_valid[i] && $urandom_range(0, 1) == 1) rand_req(i);
      if (m_valid == '0) rand_req($urandom_range(0, N - 1));
      run_txn($urandom_range(0, 3), $urandom_range(0, 3), 1'b1,
              ($urandom_range(0, 3) == 0), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
